ssd_scan_ctrl: RTL

// - Time-multiplexes the six 7-bit digit patterns from the clock's SSD decoder onto one shared

---
 rtl/ssd_pkg.sv | 50 +++++
 rtl/ssd_slot_timer.sv | 59 +++++
 rtl/ssd_scan_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display path.
// The decoder and the scan controller use the same pattern table.
// Pattern bit order is bit6 = segment A ... bit0 = segment G, active-high.
package ssd_pkg;

    // Number of digits on the board and the slot index of each digit.
    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_HR0  = 0;
    localparam int DIGIT_HR1  = 1;
    localparam int DIGIT_MIN0 = 2;
    localparam int DIGIT_MIN1 = 3;
    localparam int DIGIT_SEC0 = 4;
    localparam int DIGIT_SEC1 = 5;

    // All segments dark (active-high pattern).
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Decimal digit patterns, identical to the decoder's table.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1111110,   // 0
        7'b0110000,   // 1
        7'b1101101,   // 2
        7'b1111001,   // 3
        7'b0110011,   // 4
        7'b1011011,   // 5
        7'b1011111,   // 6
        7'b1110000,   // 7
        7'b1111111,   // 8
        7'b1111011    // 9
    };

    // Scan phase inside one digit slot.
    typedef enum logic {
        ST_BLANK = 1'b0,  // all anodes off, lets the cathodes settle
        ST_DRIVE = 1'b1   // cathodes show the digit, anode PWM active
    } scan_state_t;

    // Anode on-time inside the drive window for a brightness level.
    // Eighths of the drive window: level 7 is full drive, level 0 is one eighth.
    function automatic logic [31:0] calc_on_cycles(
        input int unsigned slot_cycles,
        input int unsigned blank_cycles,
        input logic [2:0]  bright
    );
        logic [31:0] window;
        window = slot_cycles - blank_cycles;
        return (window * (32'(bright) + 32'd1)) >> 3;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot and digit counters for the display scan.
// slot_cnt counts clk cycles inside one digit slot; idx selects the digit.
// All outputs are decoded combinationally from the two counters.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
)(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_slot_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_slot_start,
    output logic             o_slot_end,
    output logic             o_frame_start,
    output logic             o_in_drive
);

    logic [CNT_W-1:0] r_slot_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_end;
    logic             w_idx_last;

    assign w_slot_end = (r_slot_cnt == CNT_W'(SLOT_CYCLES - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Cycle counter inside a slot, wraps at the end of every slot.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        end
    end

    // Digit index, advances once per slot and wraps after the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign o_slot_cnt    = r_slot_cnt;
    assign o_idx         = r_idx;
    assign o_slot_start  = (r_slot_cnt == '0);
    assign o_slot_end    = w_slot_end;
    assign o_frame_start = (r_slot_cnt == '0) && (r_idx == '0);
    assign o_in_drive    = (32'(r_slot_cnt) >= 32'(BLANK_CYCLES));

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Six-digit seven-segment scan controller.
// Multiplexes the clock's digit patterns onto one cathode bus with per-slot
// blank time, PWM brightness, hours-tens leading-zero blanking and a PM dot.
// Inputs are captured once per frame so a mid-frame update never tears.
// All pin outputs come straight from flops that share one edge, so the anode
// and cathode buses always switch together. BLANK_CYCLES must be at least 1.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] hr0,
    input  logic [6:0] hr1,
    input  logic [6:0] min0,
    input  logic [6:0] min1,
    input  logic [6:0] sec0,
    input  logic [6:0] sec1,
    input  logic       pmlight,
    input  logic       lzb,
    input  logic [2:0] bright,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] an_n,
    output logic       frame_start
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    // Slot timing.
    logic [CNT_W-1:0] w_slot_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_slot_start;
    logic             w_slot_end;
    logic             w_frame_start;
    logic             w_in_drive;

    // Frame snapshot.
    logic [6:0]       r_snap [0:NUM_DIGITS-1];
    logic             r_snap_pm;
    logic             r_snap_lzb;

    // Brightness.
    logic [31:0]      r_on_cycles;
    logic [31:0]      w_drive_off;
    logic             w_blank_last;
    logic             w_hide_hr0;
    logic             w_anode_on;

    // FSM and output stage.
    scan_state_t      r_state;
    scan_state_t      w_next_state;
    logic [6:0]       w_seg_n_d;
    logic             w_dp_n_d;
    logic [5:0]       w_an_n_d;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic [5:0]       r_an_n;
    logic             r_frame_start;

    ssd_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W),
        .IDX_W        (IDX_W)
    ) u_slot_timer (
        .clk           (clk),
        .rst           (rst),
        .o_slot_cnt    (w_slot_cnt),
        .o_idx         (w_idx),
        .o_slot_start  (w_slot_start),
        .o_slot_end    (w_slot_end),
        .o_frame_start (w_frame_start),
        .o_in_drive    (w_in_drive)
    );

    // Capture all digit inputs once per frame so the display never tears.
    // NOTE: the snapshot array is reset element by element; it is only six
    // small registers, and a known value keeps the first frame deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= SEG_OFF;
            end
            r_snap_pm  <= 1'b0;
            r_snap_lzb <= 1'b0;
        end else if (w_frame_start) begin
            r_snap[DIGIT_HR0]  <= hr0;
            r_snap[DIGIT_HR1]  <= hr1;
            r_snap[DIGIT_MIN0] <= min0;
            r_snap[DIGIT_MIN1] <= min1;
            r_snap[DIGIT_SEC0] <= sec0;
            r_snap[DIGIT_SEC1] <= sec1;
            r_snap_pm          <= pmlight;
            r_snap_lzb         <= lzb;
        end
    end

    // Latch the anode on-time at each slot start; mid-slot changes wait a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_on_cycles <= '0;
        end else if (w_slot_start) begin
            r_on_cycles <= calc_on_cycles(SLOT_CYCLES, BLANK_CYCLES, bright);
        end
    end

    // Offset into the drive window; forced to zero during blank so it never wraps.
    assign w_drive_off  = w_in_drive ? (32'(w_slot_cnt) - 32'(BLANK_CYCLES)) : 32'd0;
    assign w_blank_last = ((32'(w_slot_cnt) + 32'd1) == 32'(BLANK_CYCLES));
    assign w_hide_hr0   = r_snap_lzb
                        && (r_snap[DIGIT_HR0] == SEG_DIGIT[0])
                        && (w_idx == IDX_W'(DIGIT_HR0));
    assign w_anode_on   = (w_drive_off < r_on_cycles) && !w_hide_hr0;

    // FSM state register: phase of the current slot_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: leave blank after its last cycle, return at slot end.
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_BLANK: if (w_blank_last) w_next_state = ST_DRIVE;
            ST_DRIVE: if (w_slot_end)   w_next_state = ST_BLANK;
            default:  w_next_state = ST_BLANK;
        endcase
    end

    // FSM outputs: dark bus in blank, digit value plus gated anode in drive.
    always_comb begin
        w_seg_n_d = ~SEG_OFF;
        w_dp_n_d  = 1'b1;
        w_an_n_d  = 6'h3F;
        unique case (r_state)
            ST_BLANK: begin
                w_seg_n_d = ~SEG_OFF;
            end
            ST_DRIVE: begin
                w_seg_n_d = ~r_snap[w_idx];
                w_dp_n_d  = ~(r_snap_pm && (w_idx == IDX_W'(DIGIT_SEC1)));
                if (w_anode_on) begin
                    w_an_n_d = ~(6'd1 << w_idx);
                end
            end
            default: begin
                w_seg_n_d = ~SEG_OFF;
            end
        endcase
    end

    // Output flops: cathodes, dot, anodes and frame pulse switch on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_n       <= ~SEG_OFF;
            r_dp_n        <= 1'b1;
            r_an_n        <= 6'h3F;
            r_frame_start <= 1'b0;
        end else begin
            r_seg_n       <= w_seg_n_d;
            r_dp_n        <= w_dp_n_d;
            r_an_n        <= w_an_n_d;
            r_frame_start <= w_frame_start;
        end
    end

    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule
